// File: rtl/add_shift_datapath.sv
// -----------------------------------------------------------------------------
// add_shift_datapath
//
// Register datapath of a shift-and-add unsigned multiplier. An external
// add/shift sequencer drives the strobes; this block holds the operands and
// the partial product, reports Q[0] back for the add decision, captures the
// finished 2n-bit product and flags protocol violations.
//
// Ports
//   clock          in   1    rising-edge clock
//   reset          in   1    asynchronous, active-high; clears all state
//   clear          in   1    clear accumulator, load operands (held in IDLE)
//   add            in   1    C:A <= A + M
//   shift          in   1    C:A:Q >> 1
//   ready          in   1    sequencer reports the multiplication finished
//   multiplicand   in   n    loaded into M on clear
//   multiplier     in   n    loaded into Q on clear
//   Q0             out  1    Q[0], read straight from the register
//   product        out  2n   captured {A,Q}; holds until the next capture
//   product_valid  out  1    product holds the most recent completed run
//   error          out  1    sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module add_shift_datapath #(
  parameter int n = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           add,
  input  logic           shift,
  input  logic           ready,
  input  logic [n-1:0]   multiplicand,
  input  logic [n-1:0]   multiplier,
  output logic           Q0,
  output logic [2*n-1:0] product,
  output logic           product_valid,
  output logic           error
);

  localparam int             CW      = $clog2(n + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(n);

  // One operation per edge, already resolved by strobe priority.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_CLEAR,
    OP_CONFLICT,   // add and shift together
    OP_ADD,
    OP_SHIFT,
    OP_OVERRUN,    // shift after n shifts already done
    OP_CAPTURE
  } op_t;

  logic [n-1:0]  m;
  logic [n-1:0]  a;
  logic          c;
  logic [n-1:0]  q;
  logic [CW-1:0] shift_cnt;
  logic          run;

  op_t           op;
  logic [n:0]    sum;

  assign Q0 = q[0];

  // Full (n+1)-bit sum; the carry lands in C so no product bit is lost.
  assign sum = {1'b0, a} + {1'b0, m};

  always_comb begin
    // NOTE: op gets a default before any branch so no path leaves it unassigned,
    // which would otherwise infer a latch.
    op = OP_IDLE;
    if (clear)               op = OP_CLEAR;
    else if (add && shift)   op = OP_CONFLICT;
    else if (add)            op = OP_ADD;
    else if (shift)          op = (shift_cnt == CNT_MAX) ? OP_OVERRUN : OP_SHIFT;
    else if (ready && run)   op = OP_CAPTURE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state is updated with non-blocking assignments only, so
      // every register samples values from before the edge regardless of order.
      m             <= '0;
      a             <= '0;
      c             <= 1'b0;
      q             <= '0;
      shift_cnt     <= '0;
      run           <= 1'b0;
      product       <= '0;
      product_valid <= 1'b0;
      error         <= 1'b0;
    end else begin
      unique case (op)
        OP_CLEAR: begin
          a         <= '0;
          c         <= 1'b0;
          m         <= multiplicand;
          q         <= multiplier;
          shift_cnt <= '0;
          run       <= 1'b0;
        end
        OP_CONFLICT: begin
          error <= 1'b1;
        end
        OP_ADD: begin
          {c, a} <= sum;
          run    <= 1'b1;
        end
        OP_SHIFT: begin
          c         <= 1'b0;
          a         <= {c, a[n-1:1]};
          q         <= {a[0], q[n-1:1]};
          shift_cnt <= shift_cnt + 1'b1;
          run       <= 1'b1;
          // The first shift marks the start of a new run: the old product is stale.
          if (shift_cnt == '0) product_valid <= 1'b0;
        end
        OP_OVERRUN: begin
          error <= 1'b1;
        end
        OP_CAPTURE: begin
          product       <= {a, q};
          product_valid <= 1'b1;
          run           <= 1'b0;
          // Early ready still captures, but the result is not a full product.
          if (shift_cnt != CNT_MAX) error <= 1'b1;
        end
        OP_IDLE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_shift_datapath.sv
// -----------------------------------------------------------------------------
// tb_add_shift_datapath
//
// Directed plus randomized bench for add_shift_datapath (n = 4). Expected
// values come from integer arithmetic: a k-step partial result is
// (mc * (mp mod 2^k)) placed above the not-yet-consumed multiplier bits.
// -----------------------------------------------------------------------------
module tb_add_shift_datapath;

  localparam int N = 4;

  logic           clock;
  logic           reset;
  logic           clear;
  logic           add;
  logic           shift;
  logic           ready;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           Q0;
  logic [2*N-1:0] product;
  logic           product_valid;
  logic           error;

  int compared   = 0;
  int mismatched = 0;

  add_shift_datapath #(.n(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .add           (add),
    .shift         (shift),
    .ready         (ready),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .Q0            (Q0),
    .product       (product),
    .product_valid (product_valid),
    .error         (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {A,Q} after k add/shift pairs of mc x mp.
  function automatic logic [2*N-1:0] exp_aq(input int mc, input int mp, input int k);
    int p;
    p = mc * (mp % (1 << k));
    return (2*N)'((p << (N - k)) | (mp >> k));
  endfunction

  // Apply one cycle of strobes; returns 1 time unit after the edge.
  task automatic step(input logic c, input logic a, input logic s, input logic r);
    clear = c; add = a; shift = s; ready = r;
    @(posedge clock);
    #1;
    clear = 1'b0; add = 1'b0; shift = 1'b0; ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic load(input int mc, input int mp);
    logic [N-1:0] mpv;
    mpv          = N'(mp);
    multiplicand = N'(mc);
    multiplier   = mpv;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("q0_after_load", 64'(Q0), 64'(mpv[0]));
  endtask

  // One add-if-bit-set plus shift; k = pairs already completed.
  task automatic pair(input int mc, input int mp, input int k);
    logic [2*N-1:0] e;
    if (((mp >> k) & 1) == 1) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    e = exp_aq(mc, mp, k + 1);
    check("q0_after_shift", 64'(Q0), 64'(e[0]));
    if (k == 0) check("valid_drops_on_first_shift", 64'(product_valid), 64'd0);
  endtask

  task automatic capture(input logic [2*N-1:0] exp_p, input logic exp_err);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("product", 64'(product), 64'(exp_p));
    check("product_valid", 64'(product_valid), 64'd1);
    check("error", 64'(error), 64'(exp_err));
  endtask

  task automatic full_run(input int mc, input int mp, input logic exp_err);
    load(mc, mp);
    for (int k = 0; k < N; k++) pair(mc, mp, k);
    capture(exp_aq(mc, mp, N), exp_err);
  endtask

  initial begin
    int mc;
    int mp;
    logic [2*N-1:0] e;

    reset = 1'b1; clear = 1'b0; add = 1'b0; shift = 1'b0; ready = 1'b0;
    multiplicand = '0; multiplier = '0;
    @(posedge clock);
    #1;
    check("reset_product", 64'(product), 64'd0);
    check("reset_valid", 64'(product_valid), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    check("reset_q0", 64'(Q0), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed products
    full_run(13, 11, 1'b0);
    check("13x11_const", 64'(product), 64'h8F);
    full_run(15, 15, 1'b0);
    check("15x15_const", 64'(product), 64'hE1);
    full_run(0, 9, 1'b0);
    check("0x9_const", 64'(product), 64'h00);

    // Ready with run=0 (after a clear) must not capture
    full_run(7, 3, 1'b0);
    load(5, 6);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ready_idle_no_capture", 64'(product), 64'd21);
    check("ready_idle_valid_held", 64'(product_valid), 64'd1);

    // Ready held after a run captures once; product stays
    for (int k = 0; k < N; k++) pair(5, 6, k);
    capture(8'd30, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ready_held_product", 64'(product), 64'd30);

    // Randomized runs
    for (int i = 0; i < 20; i++) begin
      mc = int'($urandom_range(0, (1 << N) - 1));
      mp = int'($urandom_range(0, (1 << N) - 1));
      full_run(mc, mp, 1'b0);
      check("random_product_arith", 64'(product), 64'(mc * mp));
    end

    // add & shift together mid-run: error, no datapath change, sticky
    load(6, 7);
    pair(6, 7, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("conflict_error", 64'(error), 64'd1);
    e = exp_aq(6, 7, 1);
    check("conflict_q0_unchanged", 64'(Q0), 64'(e[0]));
    for (int k = 1; k < N; k++) pair(6, 7, k);
    capture(8'd42, 1'b1);
    full_run(3, 5, 1'b1);
    pulse_reset();
    check("error_cleared_by_reset", 64'(error), 64'd0);

    // Early ready after 3 shifts
    load(13, 11);
    for (int k = 0; k < 3; k++) pair(13, 11, k);
    capture(8'h4F, 1'b1);

    // Fifth shift is an overrun with no datapath change
    pulse_reset();
    load(13, 5);
    for (int k = 0; k < N; k++) pair(13, 5, k);
    check("no_error_before_overrun", 64'(error), 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("overrun_error", 64'(error), 64'd1);
    check("overrun_q0_unchanged", 64'(Q0), 64'd1);
    capture(8'd65, 1'b1);

    // Asynchronous reset mid-run, between edges
    pulse_reset();
    full_run(2, 3, 1'b0);
    load(9, 5);
    pair(9, 5, 0);
    pair(9, 5, 1);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_product", 64'(product), 64'd0);
    check("async_reset_valid", 64'(product_valid), 64'd0);
    check("async_reset_error", 64'(error), 64'd0);
    check("async_reset_q0", 64'(Q0), 64'd0);
    #1;
    reset = 1'b0;
    full_run(9, 5, 1'b0);
    check("after_reset_product", 64'(product), 64'h2D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
